text_frame_sequencer: RTL and testbench
=======================================

// Module: text_frame_sequencer
// PURPOSE
//  Per-frame graphics sequencer: clear framebuffer, render the visible expression string as
//  multi-line text (wrap + newline), then start plot logic. Waits for swap between frames.
//  Sits between the expression buffer iterator and the fill/symbol drawers and plot logic.
// PARAMETERS
//  SYMBOL_WIDTH       7    symbol code width; code 0 = end of string
//  HOR_ACTIVE_PIXELS  640  screen width, px
//  VER_ACTIVE_PIXELS  480  screen height, px
//  SYMBOL_ADVANCE     15   horizontal pitch per glyph, px
//  LINE_ADVANCE       20   vertical pitch per text line, px
//  TEXT_LINES         2    text lines at bottom of screen (>=1)
//  TEXT_X0            0    left margin, px
//  NEWLINE_CODE       10   symbol code forcing line break (never drawn)
// PORTS
//  clk                   in   1        clock
//  rst_n                 in   1        async active-low reset
//  swap                  in   1        framebuffer swapped; sampled only in WAIT_SWAP
//  visible_iter_en       out  1        request next symbol (comb.)
//  symbol                in   SYMBOL_WIDTH  current symbol, held while symbol_valid
//  symbol_valid          in   1        symbol present
//  fill_drawer_start     out  1        1-cycle start pulse
//  fill_drawer_ready     in   1        fill drawer idle/done
//  symbol_drawer_start   out  1        1-cycle start pulse
//  symbol_drawer_ready   in   1        symbol drawer idle/done
//  symbol_drawer_symbol  out  SYMBOL_WIDTH  latched glyph code
//  symbol_drawer_x       out  clog2(HOR)    glyph x, registered
//  symbol_drawer_y       out  clog2(VER)    glyph y, registered
//  logic_start           out  1        1-cycle start pulse
//  logic_ready           in   1        plot logic done
//  text_overflow         out  1        text exceeded area this frame; cleared at FILL_START
//  frame_done            out  1        1-cycle pulse when logic completes
// BEHAVIOUR
//  - Reset (async): state=FILL_START, all pulses 0, symbol_drawer_symbol=0, x=TEXT_X0,
//    y=Y0=VER_ACTIVE_PIXELS-TEXT_LINES*LINE_ADVANCE, col=0, line=0, drop=0, text_overflow=0.
//    Reset mid-frame abandons work; first edge after release re-enters FILL_START.
//  - COLS = (HOR_ACTIVE_PIXELS-TEXT_X0)/SYMBOL_ADVANCE (default 42).
//  - States: WAIT_SWAP, FILL_START, FILL_GAP, FILL_WAIT, FETCH, SYM_START, SYM_GAP,
//    SYM_WAIT, LOGIC_START, LOGIC_GAP, LOGIC_WAIT.
//  - Handshake for every unit: X_START drives start=1 for one cycle; X_GAP ignores ready
//    (start=0); X_WAIT holds until ready=1. Min 3 cycles per transaction.
//  - WAIT_SWAP: swap=1 -> FILL_START. FILL_START also resets x,y,col,line,drop,overflow.
//  - FILL_WAIT & ready -> FETCH.
//  - FETCH: visible_iter_en = ~symbol_valid (0 in all other states). On symbol_valid:
//    * symbol==0 -> LOGIC_START (not drawn).
//    * NEWLINE_CODE: if line==TEXT_LINES-1 set drop,text_overflow; else line+1, y+=LINE_ADVANCE,
//      col=0, x=TEXT_X0. Stay FETCH.
//    * other, drop=1: consume, stay FETCH.
//    * other, col==COLS: if last line set drop,text_overflow, stay FETCH; else wrap
//      (line+1, y+=LINE_ADVANCE, col=0, x=TEXT_X0), latch symbol, -> SYM_START.
//    * other, col<COLS: latch symbol -> SYM_START.
//  - SYM_WAIT & ready: col+1, x+=SYMBOL_ADVANCE -> FETCH. x/y/symbol stable SYM_START..SYM_WAIT.
//  - LOGIC_WAIT & ready: frame_done=1 one cycle -> WAIT_SWAP.
//  - swap outside WAIT_SWAP ignored (not queued), incl. same cycle as logic_ready.
//  - Symbol interface: upstream advances only when visible_iter_en=1; one symbol consumed per
//    valid cycle in FETCH.
// TESTING
//  1 Reset release, fill_ready=1 -> fill_drawer_start pulse on 1st edge, exactly 1 cycle wide.
//  2 String "AB",0 -> draws at (0,440),(15,440); logic_start once; frame_done; then WAIT_SWAP.
//  3 43 'A' then 0 -> 43rd glyph at (0,460), no overflow.
//  4 'A',10,'B',10,'C',0 -> A(0,440), B(0,460), C dropped, text_overflow=1 until next FILL_START.
//  5 symbol_drawer_ready held 1 throughout -> each glyph still gets GAP cycle; no double start.
//  6 rst_n low during SYM_WAIT -> outputs to reset values immediately; restart with fill.

Source files
------------

// File: rtl/text_frame_sequencer.sv
// Per-frame graphics sequencer: clear the framebuffer, draw the expression text as wrapped
// lines at the bottom of the screen, run plot logic, then wait for a buffer swap.
module text_frame_sequencer #(
  parameter int SYMBOL_WIDTH      = 7,
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int SYMBOL_ADVANCE    = 15,
  parameter int LINE_ADVANCE      = 20,
  parameter int TEXT_LINES        = 2,
  parameter int TEXT_X0           = 0,
  parameter int NEWLINE_CODE      = 10
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_swap,
  output logic                                 o_visible_iter_en,
  input  logic [SYMBOL_WIDTH-1:0]              i_symbol,
  input  logic                                 i_symbol_valid,
  output logic                                 o_fill_drawer_start,
  input  logic                                 i_fill_drawer_ready,
  output logic                                 o_symbol_drawer_start,
  input  logic                                 i_symbol_drawer_ready,
  output logic [SYMBOL_WIDTH-1:0]              o_symbol_drawer_symbol,
  output logic [$clog2(HOR_ACTIVE_PIXELS)-1:0] o_symbol_drawer_x,
  output logic [$clog2(VER_ACTIVE_PIXELS)-1:0] o_symbol_drawer_y,
  output logic                                 o_logic_start,
  input  logic                                 i_logic_ready,
  output logic                                 o_text_overflow,
  output logic                                 o_frame_done
);

  localparam int XW   = $clog2(HOR_ACTIVE_PIXELS);
  localparam int YW   = $clog2(VER_ACTIVE_PIXELS);
  localparam int COLS = (HOR_ACTIVE_PIXELS - TEXT_X0) / SYMBOL_ADVANCE;
  localparam int CW   = $clog2(COLS + 1);
  localparam int LW   = (TEXT_LINES > 1) ? $clog2(TEXT_LINES) : 1;

  localparam logic [XW-1:0]           X0        = XW'(TEXT_X0);
  localparam logic [YW-1:0]           Y0        = YW'(VER_ACTIVE_PIXELS - TEXT_LINES * LINE_ADVANCE);
  localparam logic [XW-1:0]           X_ADV     = XW'(SYMBOL_ADVANCE);
  localparam logic [YW-1:0]           Y_ADV     = YW'(LINE_ADVANCE);
  localparam logic [CW-1:0]           COLS_C    = CW'(COLS);
  localparam logic [LW-1:0]           LAST_LINE = LW'(TEXT_LINES - 1);
  localparam logic [SYMBOL_WIDTH-1:0] NL_CODE   = SYMBOL_WIDTH'(NEWLINE_CODE);
  localparam logic [SYMBOL_WIDTH-1:0] END_CODE  = '0;

  typedef enum logic [3:0] {
    S_WAIT_SWAP,
    S_FILL_START,
    S_FILL_GAP,
    S_FILL_WAIT,
    S_FETCH,
    S_SYM_START,
    S_SYM_GAP,
    S_SYM_WAIT,
    S_LOGIC_START,
    S_LOGIC_GAP,
    S_LOGIC_WAIT
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [SYMBOL_WIDTH-1:0] r_sym, w_sym_nxt;
  logic [XW-1:0]           r_x, w_x_nxt;
  logic [YW-1:0]           r_y, w_y_nxt;
  logic [CW-1:0]           r_col, w_col_nxt;
  logic [LW-1:0]           r_line, w_line_nxt;
  logic                    r_drop, w_drop_nxt;
  logic                    r_ovf, w_ovf_nxt;
  logic                    r_fill_start, w_fill_start_nxt;
  logic                    r_sym_start, w_sym_start_nxt;
  logic                    r_logic_start, w_logic_start_nxt;
  logic                    r_frame_done, w_frame_done_nxt;
  logic                    w_last_line;

  assign w_last_line = (r_line == LAST_LINE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_FILL_START;
      r_sym         <= '0;
      r_x           <= X0;
      r_y           <= Y0;
      r_col         <= '0;
      r_line        <= '0;
      r_drop        <= 1'b0;
      r_ovf         <= 1'b0;
      r_fill_start  <= 1'b0;
      r_sym_start   <= 1'b0;
      r_logic_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sym         <= w_sym_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_col         <= w_col_nxt;
      r_line        <= w_line_nxt;
      r_drop        <= w_drop_nxt;
      r_ovf         <= w_ovf_nxt;
      r_fill_start  <= w_fill_start_nxt;
      r_sym_start   <= w_sym_start_nxt;
      r_logic_start <= w_logic_start_nxt;
      r_frame_done  <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_sym_nxt         = r_sym;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_col_nxt         = r_col;
    w_line_nxt        = r_line;
    w_drop_nxt        = r_drop;
    w_ovf_nxt         = r_ovf;
    w_fill_start_nxt  = 1'b0;
    w_sym_start_nxt   = 1'b0;
    w_logic_start_nxt = 1'b0;
    w_frame_done_nxt  = 1'b0;

    case (r_state)
      S_WAIT_SWAP: begin
        if (i_swap) w_state_nxt = S_FILL_START;
      end
      S_FILL_START: begin
        w_fill_start_nxt = 1'b1;
        w_x_nxt          = X0;
        w_y_nxt          = Y0;
        w_col_nxt        = '0;
        w_line_nxt       = '0;
        w_drop_nxt       = 1'b0;
        w_ovf_nxt        = 1'b0;
        w_state_nxt      = S_FILL_GAP;
      end
      S_FILL_GAP:  w_state_nxt = S_FILL_WAIT;
      S_FILL_WAIT: begin
        if (i_fill_drawer_ready) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (i_symbol_valid) begin
          if (i_symbol == END_CODE) begin
            w_state_nxt = S_LOGIC_START;
          end else if (i_symbol == NL_CODE) begin
            if (w_last_line) begin
              w_drop_nxt = 1'b1;
              w_ovf_nxt  = 1'b1;
            end else begin
              w_line_nxt = r_line + LW'(1);
              w_y_nxt    = r_y + Y_ADV;
              w_col_nxt  = '0;
              w_x_nxt    = X0;
            end
          end else if (r_drop) begin
            w_state_nxt = S_FETCH;
          end else if (r_col == COLS_C) begin
            // A full line on the last text row overflows; elsewhere it wraps.
            if (w_last_line) begin
              w_drop_nxt = 1'b1;
              w_ovf_nxt  = 1'b1;
            end else begin
              w_line_nxt  = r_line + LW'(1);
              w_y_nxt     = r_y + Y_ADV;
              w_col_nxt   = '0;
              w_x_nxt     = X0;
              w_sym_nxt   = i_symbol;
              w_state_nxt = S_SYM_START;
            end
          end else begin
            w_sym_nxt   = i_symbol;
            w_state_nxt = S_SYM_START;
          end
        end
      end
      S_SYM_START: begin
        w_sym_start_nxt = 1'b1;
        w_state_nxt     = S_SYM_GAP;
      end
      S_SYM_GAP:  w_state_nxt = S_SYM_WAIT;
      S_SYM_WAIT: begin
        if (i_symbol_drawer_ready) begin
          w_col_nxt   = r_col + CW'(1);
          w_x_nxt     = r_x + X_ADV;
          w_state_nxt = S_FETCH;
        end
      end
      S_LOGIC_START: begin
        w_logic_start_nxt = 1'b1;
        w_state_nxt       = S_LOGIC_GAP;
      end
      S_LOGIC_GAP:  w_state_nxt = S_LOGIC_WAIT;
      S_LOGIC_WAIT: begin
        if (i_logic_ready) begin
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = S_WAIT_SWAP;
        end
      end
      default: w_state_nxt = S_FILL_START;
    endcase
  end

  assign o_visible_iter_en      = (r_state == S_FETCH) && !i_symbol_valid;
  assign o_fill_drawer_start    = r_fill_start;
  assign o_symbol_drawer_start  = r_sym_start;
  assign o_symbol_drawer_symbol = r_sym;
  assign o_symbol_drawer_x      = r_x;
  assign o_symbol_drawer_y      = r_y;
  assign o_logic_start          = r_logic_start;
  assign o_text_overflow        = r_ovf;
  assign o_frame_done           = r_frame_done;

endmodule

// File: tb/tb_text_frame_sequencer.sv
// Directed bench for text_frame_sequencer: models the symbol source and the three
// handshaking units, logs every glyph start and checks against hand-computed values.
module tb_text_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       swap = 1'b0;
  logic       iter_en;
  logic [6:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic       fill_start, fill_rdy = 1'b1;
  logic       sym_start, sym_rdy = 1'b1;
  logic [6:0] draw_sym;
  logic [9:0] draw_x;
  logic [8:0] draw_y;
  logic       logic_start, logic_rdy = 1'b1;
  logic       overflow, frame_done;

  always #5 clk = ~clk;

  text_frame_sequencer dut (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_swap                 (swap),
    .o_visible_iter_en      (iter_en),
    .i_symbol               (sym_in),
    .i_symbol_valid         (sym_valid),
    .o_fill_drawer_start    (fill_start),
    .i_fill_drawer_ready    (fill_rdy),
    .o_symbol_drawer_start  (sym_start),
    .i_symbol_drawer_ready  (sym_rdy),
    .o_symbol_drawer_symbol (draw_sym),
    .o_symbol_drawer_x      (draw_x),
    .o_symbol_drawer_y      (draw_y),
    .o_logic_start          (logic_start),
    .i_logic_ready          (logic_rdy),
    .o_text_overflow        (overflow),
    .o_frame_done           (frame_done)
  );

  int checks = 0, passes = 0, fails = 0;
  logic [6:0] seq [64];
  int slen = 0, sidx = 0;
  logic present = 1'b0;
  int fill_lat = 0, sym_lat = 2, logic_lat = 3;
  int fcnt = 0, scnt = 0, lcnt = 0;
  int fill_n = 0, sym_n = 0, logic_n = 0, done_n = 0, dbl = 0, unstable = 0;
  logic sym_prev = 1'b0;
  logic [6:0] ds [64];
  logic [9:0] dx [64];
  logic [8:0] dy [64];
  int ndraw = 0;
  int sn0;

  // Source and unit models, acting on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sym_valid = 1'b0; present = 1'b0;
      fill_rdy = 1'b1; sym_rdy = 1'b1; logic_rdy = 1'b1;
      fcnt = 0; scnt = 0; lcnt = 0; sym_prev = 1'b0;
    end else begin
      if (present) begin
        sym_valid = 1'b0; present = 1'b0;
      end else if (iter_en && sidx < slen) begin
        sym_in = seq[sidx]; sidx++; sym_valid = 1'b1; present = 1'b1;
      end
      if (fill_start) begin
        fill_n++;
        if (fill_lat > 0) begin fill_rdy = 1'b0; fcnt = fill_lat; end
      end else if (fcnt > 0) begin
        fcnt--; if (fcnt == 0) fill_rdy = 1'b1;
      end
      if (sym_start) begin
        if (sym_prev) dbl++;
        sym_n++;
        if (ndraw < 64) begin ds[ndraw] = draw_sym; dx[ndraw] = draw_x; dy[ndraw] = draw_y; end
        ndraw++;
        if (sym_lat > 0) begin sym_rdy = 1'b0; scnt = sym_lat; end
      end else if (scnt > 0) begin
        if (ndraw > 0 && ndraw <= 64 &&
            (draw_x !== dx[ndraw-1] || draw_y !== dy[ndraw-1] || draw_sym !== ds[ndraw-1]))
          unstable++;
        scnt--; if (scnt == 0) sym_rdy = 1'b1;
      end
      sym_prev = sym_start;
      if (logic_start) begin
        logic_n++;
        if (logic_lat > 0) begin logic_rdy = 1'b0; lcnt = logic_lat; end
      end else if (lcnt > 0) begin
        lcnt--; if (lcnt == 0) logic_rdy = 1'b1;
      end
      if (frame_done) done_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [6:0] c);
    seq[slen] = c;
    slen++;
  endtask

  task automatic load_str(input string s);
    logic [7:0] ch;
    slen = 0; sidx = 0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s[i];
      push(ch[6:0]);
    end
    push(7'd0);
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 4000 && done_n < target; i++) tick();
    check(tag, done_n, target);
  endtask

  task automatic wait_draws(input int n, input string tag);
    for (int i = 0; i < 4000 && ndraw < n; i++) tick();
    check(tag, (ndraw >= n) ? 1 : 0, 1);
  endtask

  initial begin
    // Reset state
    load_str("AB");
    tick(); tick();
    check("rst_fill_start", fill_start, 0);
    check("rst_sym_start", sym_start, 0);
    check("rst_logic_start", logic_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_x", draw_x, 0);
    check("rst_y", draw_y, 440);
    check("rst_symbol", draw_sym, 0);
    check("rst_overflow", overflow, 0);
    check("rst_iter_en", iter_en, 0);

    // 1: fill start pulse on first edge, one cycle wide
    rst_n = 1'b1;
    tick();
    check("t1_fill_pulse", fill_start, 1);
    tick();
    check("t1_fill_width", fill_start, 0);

    // 2: "AB" then end
    wait_done(1, "t2_done");
    check("t2_ndraw", ndraw, 2);
    check("t2_sym0", ds[0], 65);
    check("t2_x0", dx[0], 0);
    check("t2_y0", dy[0], 440);
    check("t2_sym1", ds[1], 66);
    check("t2_x1", dx[1], 15);
    check("t2_y1", dy[1], 440);
    check("t2_logic_starts", logic_n, 1);
    check("t2_overflow", overflow, 0);
    repeat (5) tick();
    check("t2_no_refill", fill_n, 1);
    check("t2_done_once", done_n, 1);
    check("t2_iter_idle", iter_en, 0);

    // 3: 43 glyphs wrap onto second line; stray swap mid-frame ignored
    slen = 0; sidx = 0;
    for (int i = 0; i < 43; i++) push(7'd65);
    push(7'd0);
    ndraw = 0; sym_lat = 1;
    pulse_swap();
    wait_draws(5, "t3_progress");
    pulse_swap();
    wait_done(2, "t3_done");
    check("t3_ndraw", ndraw, 43);
    check("t3_x41", dx[41], 615);
    check("t3_y41", dy[41], 440);
    check("t3_x42", dx[42], 0);
    check("t3_y42", dy[42], 460);
    check("t3_sym42", ds[42], 65);
    check("t3_overflow", overflow, 0);
    repeat (6) tick();
    check("t3_swap_ignored", fill_n, 2);

    // 4: newline on last line drops the rest and flags overflow
    slen = 0; sidx = 0;
    push(7'd65); push(7'd10); push(7'd66); push(7'd10); push(7'd67); push(7'd0);
    ndraw = 0;
    pulse_swap();
    wait_done(3, "t4_done");
    check("t4_ndraw", ndraw, 2);
    check("t4_x0", dx[0], 0);
    check("t4_y0", dy[0], 440);
    check("t4_sym1", ds[1], 66);
    check("t4_x1", dx[1], 0);
    check("t4_y1", dy[1], 460);
    check("t4_overflow", overflow, 1);
    repeat (4) tick();
    check("t4_overflow_held", overflow, 1);

    // 5: symbol drawer ready held high; overflow clears at fill start
    sym_lat = 0;
    load_str("XYZ");
    ndraw = 0; sn0 = sym_n;
    pulse_swap();
    check("t4_ovf_in_fill_start", overflow, 1);
    tick();
    check("t4_ovf_cleared", overflow, 0);
    wait_done(4, "t5_done");
    check("t5_sym_starts", sym_n - sn0, 3);
    check("t5_double_start", dbl, 0);
    check("t5_x2", dx[2], 30);
    check("t5_sym2", ds[2], 90);
    check("t5_overflow", overflow, 0);

    // 6: reset during SYM_WAIT
    sym_lat = 20;
    load_str("ABC");
    ndraw = 0;
    pulse_swap();
    wait_draws(2, "t6_progress");
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t6_x", draw_x, 0);
    check("t6_y", draw_y, 440);
    check("t6_symbol", draw_sym, 0);
    check("t6_sym_start", sym_start, 0);
    check("t6_overflow", overflow, 0);
    check("t6_iter_en", iter_en, 0);
    tick(); tick();
    fill_n = 0; ndraw = 0; done_n = 0; sym_lat = 2;
    load_str("Q");
    rst_n = 1'b1;
    tick();
    check("t6_fill_pulse", fill_start, 1);
    wait_done(1, "t6_done");
    check("t6_ndraw", ndraw, 1);
    check("t6_sym0", ds[0], 81);
    check("t6_x0", dx[0], 0);
    check("t6_y0", dy[0], 440);
    check("t6_fill_once", fill_n, 1);

    check("all_no_double_start", dbl, 0);
    check("all_glyph_stable", unstable, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
